// File: rtl/loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        StSync,
        StLen,
        StData,
        StChk,
        StRun,
        StErr
    } state_t;

    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;
    localparam logic [31:0] DEFAULT_NOP_INSN  = 32'h00000013;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction RAM: synchronous write, asynchronous read.
module imem_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Loads a framed program image from a byte stream into instruction RAM and
// holds the core in reset until the image checksum has been verified.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter logic [31:0] NOP_INSN  = DEFAULT_NOP_INSN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        load_req,
    input  logic [31:0] address,
    output logic [31:0] instruction,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_t      state;
    state_t      state_next;
    logic [15:0] len;
    logic [1:0]  byte_cnt;
    logic [23:0] word_lo;
    logic [7:0]  checksum;
    logic        accept;
    logic [16:0] len_full;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        unused_addr_bits;

    assign rx_ready = (state == StSync) || (state == StLen) ||
                      (state == StData) || (state == StChk);
    assign accept   = rx_valid && rx_ready;
    // Length as it will be once the high byte now on the bus is latched.
    assign len_full = {1'b0, rx_data, len[7:0]};

    assign ram_we    = accept && (state == StData) && (byte_cnt == 2'd3);
    assign ram_wdata = {rx_data, word_lo};

    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (words_loaded[AW-1:0]),
        .wdata (ram_wdata),
        .raddr (address[AW+1:2]),
        .rdata (ram_rdata)
    );

    assign instruction = ((state == StRun) && (address[31:AW+2] == '0)) ? ram_rdata : NOP_INSN;
    assign unused_addr_bits = ^address[1:0];

    always_comb begin
        state_next = state;
        unique case (state)
            StSync: begin
                if (accept && (rx_data == SYNC_BYTE)) begin
                    state_next = StLen;
                end
            end
            StLen: begin
                if (accept && (byte_cnt == 2'd1)) begin
                    if (len_full > 17'(DEPTH)) begin
                        state_next = StErr;
                    end else if (len_full == 17'd0) begin
                        state_next = StChk;
                    end else begin
                        state_next = StData;
                    end
                end
            end
            StData: begin
                if (ram_we && ((words_loaded + 16'd1) == len)) begin
                    state_next = StChk;
                end
            end
            StChk: begin
                if (accept) begin
                    state_next = (rx_data == checksum) ? StRun : StErr;
                end
            end
            StRun: begin
                if (load_req) begin
                    state_next = StSync;
                end
            end
            StErr: state_next = StErr;
            default: state_next = StSync;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StSync;
            core_reset   <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= 16'd0;
            byte_cnt     <= 2'd0;
            checksum     <= 8'd0;
            len          <= 16'd0;
            word_lo      <= 24'd0;
        end else begin
            state      <= state_next;
            core_reset <= (state_next != StRun);
            busy       <= (state_next == StSync) || (state_next == StLen) ||
                          (state_next == StData) || (state_next == StChk);
            done       <= (state_next == StRun);
            err        <= (state_next == StErr);
            if (accept) begin
                case (state)
                    StSync: begin
                        if (rx_data == SYNC_BYTE) begin
                            words_loaded <= 16'd0;
                            checksum     <= 8'd0;
                            byte_cnt     <= 2'd0;
                        end
                    end
                    StLen: begin
                        if (byte_cnt == 2'd0) begin
                            len[7:0] <= rx_data;
                            byte_cnt <= 2'd1;
                        end else begin
                            len[15:8] <= rx_data;
                            byte_cnt  <= 2'd0;
                        end
                    end
                    StData: begin
                        checksum <= checksum ^ rx_data;
                        // Shift in LE order; after three bytes word_lo holds {b2, b1, b0}.
                        word_lo  <= {rx_data, word_lo[23:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            words_loaded <= words_loaded + 16'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected status, a monitor compares.
module tb_imem_loader;
    import loader_pkg::*;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        load_req = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] instruction;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic        cr;
        logic        bz;
        logic        dn;
        logic        er;
        logic        rdy;
        logic [15:0] wl;
        logic [31:0] insn;
    } exp_t;

    exp_t sb[$];

    imem_loader #(
        .DEPTH (256)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .load_req     (load_req),
        .address      (address),
        .instruction  (instruction),
        .core_reset   (core_reset),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    function automatic void cmp(input string nm, input string fld,
                                input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, expv);
        end
    endfunction

    // Monitor: one expectation is consumed per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.name, "core_reset", 32'(core_reset), 32'(e.cr));
                cmp(e.name, "busy", 32'(busy), 32'(e.bz));
                cmp(e.name, "done", 32'(done), 32'(e.dn));
                cmp(e.name, "err", 32'(err), 32'(e.er));
                cmp(e.name, "rx_ready", 32'(rx_ready), 32'(e.rdy));
                cmp(e.name, "words_loaded", 32'(words_loaded), 32'(e.wl));
                cmp(e.name, "instruction", instruction, e.insn);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic expect_st(input string nm, input logic cr, input logic bz, input logic dn,
                             input logic er, input logic rdy, input logic [15:0] wl,
                             input logic [31:0] addr, input logic [31:0] insn);
        exp_t e;
        address = addr;
        e.name = nm; e.cr = cr; e.bz = bz; e.dn = dn; e.er = er;
        e.rdy = rdy; e.wl = wl; e.insn = insn;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.monitor: %0d entries pending expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic expect_run(input string nm, input logic [15:0] wl,
                              input logic [31:0] addr, input logic [31:0] insn);
        expect_st(nm, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, wl, addr, insn);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit jitter);
        logic rdy;
        int   waited;
        if (jitter) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        waited   = 0;
        forever begin
            @(negedge clk);
            rdy = rx_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 20) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_byte: byte %h not accepted expected accept within 20 cycles", b);
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] bytes[$], input bit jitter);
        foreach (bytes[i]) send_byte(bytes[i], jitter);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        load_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    initial begin
        logic [7:0] happy_body[$];
        happy_body = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                       8'hB3, 8'h00, 8'h00, 8'h00};

        // Reset state
        do_reset();
        expect_st("reset", 1, 1, 0, 0, 1, 16'd0, 32'h0, NOP);

        // Happy path
        send_seq(happy_body, 1'b0);
        expect_st("happy_chk", 1, 1, 0, 0, 1, 16'd2, 32'h0, NOP);
        send_byte(8'hA0, 1'b0);
        expect_run("happy_run_a0", 16'd2, 32'h0, 32'h00000013);
        expect_run("happy_run_a4", 16'd2, 32'h4, 32'h000000B3);
        expect_run("align_a6", 16'd2, 32'h6, 32'h000000B3);
        expect_run("range_400", 16'd2, 32'h400, NOP);

        // Reload from RUN
        pulse_load();
        expect_st("reload_sync", 1, 1, 0, 0, 1, 16'd2, 32'h0, NOP);
        send_seq('{8'hA5, 8'h01, 8'h00, 8'h37, 8'h12, 8'h00, 8'h00, 8'h25}, 1'b0);
        expect_run("reload_a0", 16'd1, 32'h0, 32'h00001237);
        expect_run("reload_keep_a4", 16'd1, 32'h4, 32'h000000B3);

        // Mid-frame reset, then zero-length frame to view retained RAM
        pulse_load();
        send_seq('{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB}, 1'b0);
        do_reset();
        expect_st("midreset", 1, 1, 0, 0, 1, 16'd0, 32'h0, NOP);
        send_seq('{8'hA5, 8'h00, 8'h00}, 1'b0);
        expect_st("zero_chk", 1, 1, 0, 0, 1, 16'd0, 32'h0, NOP);
        send_byte(8'h00, 1'b0);
        expect_run("zero_run_a0", 16'd0, 32'h0, 32'h00001237);
        expect_run("zero_run_a4", 16'd0, 32'h4, 32'h000000B3);

        // Sync hunting with random rx_valid gaps
        do_reset();
        send_seq('{8'h00, 8'hFF, 8'h5A}, 1'b1);
        expect_st("hunt_sync", 1, 1, 0, 0, 1, 16'd0, 32'h0, NOP);
        send_seq(happy_body, 1'b1);
        send_byte(8'hA0, 1'b1);
        expect_run("hunt_a0", 16'd2, 32'h0, 32'h00000013);
        expect_run("hunt_a4", 16'd2, 32'h4, 32'h000000B3);

        // Bad checksum: sticky ERR
        do_reset();
        send_seq(happy_body, 1'b0);
        send_byte(8'h00, 1'b0);
        expect_st("badchk", 1, 0, 0, 1, 0, 16'd2, 32'h0, NOP);
        pulse_load();
        expect_st("badchk_sticky", 1, 0, 0, 1, 0, 16'd2, 32'h4, NOP);

        // Oversize length
        do_reset();
        send_seq('{8'hA5, 8'h01}, 1'b0);
        expect_st("oversize_lo", 1, 1, 0, 0, 1, 16'd0, 32'h0, NOP);
        send_byte(8'h01, 1'b0);
        expect_st("oversize_err", 1, 0, 0, 1, 0, 16'd0, 32'h0, NOP);

        do_reset();
        expect_st("final_reset", 1, 1, 0, 0, 1, 16'd0, 32'h0, NOP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction-memory front end that sits directly upstream of the single-cycle core.
- Accepts a framed program image over a byte stream and writes it into an internal instruction RAM.
- Holds the core in reset while loading; releases it only after a valid checksum.
- Serves `instruction` combinationally from the core's PC `address`.

Parameters:
- DEPTH, 256, number of 32-bit instruction words in the RAM (power of two, ≥4).
- SYNC_BYTE, 8'hA5, frame start marker.
- NOP_INSN, 32'h00000013, instruction returned when the core must not see RAM contents.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- rx_valid  in  1  a byte is offered on rx_data.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader can accept a byte; a transfer occurs on a cycle where rx_valid && rx_ready.
- load_req  in  1  single-cycle pulse; requests a reload from RUN.
- address  in  32  core PC (byte address).
- instruction  out  32  word fetched for address.
- core_reset  out  1  drives the core's reset; high while not in RUN.
- busy  out  1  high in SYNC/LEN/DATA/CHK.
- done  out  1  high in RUN.
- err  out  1  high in ERR.
- words_loaded  out  16  count of words written in the current frame.

Behaviour:
- Reset (sync): state=SYNC, core_reset=1, busy=1, done=0, err=0, words_loaded=0, byte/word counters=0, checksum=0. RAM contents are not cleared.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI (word count N, 16-bit LE), then N words of 4 bytes each (LE), then CHK. CHK is the XOR of all 4N data bytes.
- rx_ready=1 in SYNC, LEN, DATA, CHK; rx_ready=0 in RUN and ERR.
- State machine (all transitions on an accepted byte unless noted):
  - SYNC: byte==SYNC_BYTE → LEN (clear words_loaded, checksum); any other byte is discarded and the state stays SYNC.
  - LEN: first byte → len[7:0]; second byte → len[15:8]. After the second byte:
    - N>DEPTH → ERR.
    - N==0 → CHK.
    - otherwise → DATA.
  - DATA: assemble bytes LE into a word and XOR each byte into checksum. On the 4th byte, write the word to RAM[words_loaded] at that edge and increment words_loaded. When words_loaded reaches N → CHK.
  - CHK: byte==checksum → RUN; otherwise → ERR.
  - RUN: core_reset=0, done=1. load_req → SYNC (core_reset=1 in the next cycle). rx bytes are ignored.
  - ERR: sticky until reset. core_reset=1, err=1. load_req is ignored.
- Register timing:
  - Status outputs and core_reset are registered; they reflect the new state one cycle after the accepting edge.
  - core_reset falls on the first cycle in RUN.
- Instruction read path:
  - Index = address[AW+1:2], with AW=$clog2(DEPTH).
  - instruction = RAM[index] only when state==RUN and address[31:AW+2]==0. In all other cases (not RUN, or out-of-range address) instruction = NOP_INSN.
  - address[1:0] is ignored.
  - A word written on edge k is readable in RUN from edge k+1 onward (write-before-read is never required).
- Simultaneous events:
  - load_req in any state other than RUN is ignored.
  - reset dominates load_req and rx traffic.
  - Reset mid-frame abandons the frame. Words already written stay in RAM; words_loaded returns to 0.
- Widths: len and words_loaded are 16-bit, so the compare N>DEPTH uses 17-bit arithmetic. The byte counter is 2 bits and wraps after the 4th byte.

Decomposition:
- Shared package `loader_pkg`:
  - state enum: SYNC, LEN, DATA, CHK, RUN, ERR.
  - default SYNC_BYTE and NOP_INSN constants.
- One sub-module, `imem_ram`:
  - DEPTH×32 array.
  - Synchronous write port (we, waddr, wdata); asynchronous read port (raddr → rdata).
  - The out-of-range/NOP mux stays in the parent.

Test Plan:
- Happy path:
  - Stimulus: reset, then A5, 02, 00, bytes 13 00 00 00, B3 00 00 00, CHK=A0.
  - Response: RUN; core_reset drops one cycle after CHK; words_loaded=2; address=0 → 32'h00000013; address=4 → 32'h000000B3.
- Bad checksum:
  - Stimulus: the same frame with CHK=00.
  - Response: err=1, core_reset=1, rx_ready=0, instruction=NOP_INSN; state stays ERR until reset.
- Oversize and zero length:
  - Stimulus: LEN=0x0101 with DEPTH=256.
  - Response: ERR right after LEN_HI.
  - Stimulus: LEN=0 followed by CHK=00.
  - Response: RUN, words_loaded=0.
- Sync hunting and backpressure:
  - Stimulus: garbage bytes 00, FF, 5A ahead of a valid frame, with rx_valid toggled randomly.
  - Response: the garbage is discarded; the load succeeds identically to the happy path.
- Address range and alignment:
  - Stimulus: in RUN, address=32'h400 (DEPTH=256).
  - Response: NOP_INSN.
  - Stimulus: address=32'h6.
  - Response: same word as address=4.
- Reload and mid-frame reset:
  - Stimulus: load_req in RUN.
  - Response: core_reset=1 the next cycle; new frame loads.
  - Stimulus: reset after the 2nd data byte.
  - Response: SYNC, words_loaded=0, earlier RAM words retained.
